mul256_seq: RTL and testbench
=============================

MUL256_SEQ -- requirements
Module: mul256_seq

Interface
REQ-001 SHALL have parameter W, default 256, operand width in bits; the product is 2*W bits.
REQ-002 SHALL have port clk, input, 1 bit: sole clock, rising-edge active.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port start, input, 1 bit: request pulse, sampled only in IDLE.
REQ-005 SHALL have port a, input, W bits: multiplicand, unsigned.
REQ-006 SHALL have port b, input, W bits: multiplier, unsigned.
REQ-007 SHALL have port busy, output, 1 bit: high while an operation is in flight.
REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse when p becomes valid.
REQ-009 SHALL have port p, output, 2*W bits: unsigned product a*b, in the 512-bit format consumed by the modular-reduction stage.

Function
REQ-010 SHALL use a three-state FSM with states IDLE, RUN and DONE.
REQ-011 IDLE with start=1 SHALL latch a into the multiplicand register, b into the low half of the product register, and zero into the high half.
REQ-012 The same IDLE-accept edge SHALL clear the iteration counter, set busy=1 and move the FSM to RUN.
REQ-013 IDLE with start=0 SHALL hold all registers, p included.
REQ-014 Each RUN cycle SHALL compute hi' = hi + (lo[0] ? multiplicand : 0), W+1 bits with carry kept.
REQ-015 Each RUN cycle SHALL then right-shift {carry, hi', lo} by one bit into {hi, lo}, so no carry is ever discarded.
REQ-016 RUN SHALL perform exactly W iterations; the counter is $clog2(W)+1 bits wide and increments once per RUN cycle.
REQ-017 On the edge completing iteration W, the block SHALL load p with {hi, lo}, set busy=0, set done=1 and move the FSM to DONE.
REQ-018 DONE SHALL clear done and return to IDLE on the next edge, so done is high for exactly one cycle.
REQ-019 Latency SHALL be exactly W cycles: start is accepted at edge E0, and busy=0 with done=1 and p valid after edge E(W) (E256 for W=256).
REQ-020 start asserted in RUN or DONE SHALL be ignored; it is not queued, and operands are not re-latched.
REQ-021 start in the first IDLE cycle after DONE SHALL be accepted, giving back-to-back throughput of one result per W+2 cycles.
REQ-022 p SHALL hold its last value until the next completion; p is not updated during RUN.
REQ-023 a and b SHALL be sampled only on the accept edge; later changes to a or b SHALL not affect the result.
REQ-024 The result SHALL be exact for all operands, including 0 and 2^W-1.

Reset
REQ-025 rst=1 at a clk edge SHALL force state=IDLE, busy=0, done=0, p=0, counter=0, and clear the product and multiplicand registers.
REQ-026 rst SHALL take priority over start and over any in-flight RUN iteration; an aborted operation SHALL produce no done pulse.
REQ-027 The first cycle after rst deasserts SHALL accept start.

Structure
REQ-028 A shared package SHALL hold W (256), the FSM state enum (IDLE, RUN, DONE) and the product width constant 2*W, all shared with the reduction stage.
REQ-029 The block SHALL be a single module with no sub-module; the (W+1)-bit conditional adder is inline.

Verification
REQ-030 a=0, b=2^256-1, start pulse -> done after exactly 256 cycles, p=0, busy high for 256 cycles.
REQ-031 a=2^256-1, b=2^256-1 -> p=2^512-2^257+1.
REQ-032 a=2^255, b=2 -> p=2^256; feeding p to the reduction stage -> reduced output 2^32+977.
REQ-033 start held high throughout RUN, with a and b changed mid-run -> the result equals the product of the originally latched operands, and exactly one done pulse occurs.
REQ-034 rst pulsed at iteration 100 -> busy=0, p=0, no done pulse; a new start then completes in exactly 256 cycles.
REQ-035 Two back-to-back operations (3*5, then 7*11), with start reasserted in the first IDLE cycle -> p=15 then p=77, with done pulses 258 cycles apart.

Source files
------------

// File: rtl/mul256_seq_pkg.sv
// Constants and FSM encoding shared by the 256-bit multiplier and the modular-reduction stage.
// The product width is fixed at twice the operand width.
package mul256_seq_pkg;

  localparam int MUL_W  = 256;
  localparam int MUL_PW = 2 * MUL_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mul256_seq.sv
// Sequential shift-add unsigned multiplier: one multiplier bit per RUN cycle, W cycles from accept to done.
// No backpressure: start is taken only in IDLE, ignored (not queued) while busy or in DONE.
module mul256_seq
  import mul256_seq_pkg::*;
#(
  parameter int W = MUL_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  output logic             busy,
  output logic             done,
  output logic [2*W-1:0]   p
);

  localparam int              CW   = $clog2(W) + 1;
  localparam logic [CW-1:0]   LAST = CW'(W - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [W-1:0]     r_mcand;
  logic [W-1:0]     r_hi;
  logic [W-1:0]     r_lo;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [2*W-1:0]   r_p;

  logic             w_accept;
  logic             w_last;
  logic [W:0]       w_sum;
  logic [W-1:0]     w_hi_nxt;
  logic [W-1:0]     w_lo_nxt;

  assign w_accept = (r_state == IDLE) && start;
  assign w_last   = (r_state == RUN) && (r_cnt == LAST);

  // Carry bit of the add is kept and shifted down into hi, so nothing is lost.
  assign w_sum    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mcand} : {(W+1){1'b0}});
  assign w_hi_nxt = w_sum[W:1];
  assign w_lo_nxt = {w_sum[0], r_lo[W-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start)  w_state_nxt = RUN;
      RUN:     if (w_last) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mcand <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_p     <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_mcand <= a;
        r_hi    <= '0;
        r_lo    <= b;
        r_cnt   <= '0;
        r_busy  <= 1'b1;
      end else if (r_state == RUN) begin
        r_hi  <= w_hi_nxt;
        r_lo  <= w_lo_nxt;
        r_cnt <= r_cnt + 1'b1;
        if (w_last) begin
          r_p    <= {w_hi_nxt, w_lo_nxt};
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign p    = r_p;

endmodule

// File: tb/tb_mul256_seq.sv
// Self-checking bench for mul256_seq: directed corner cases plus random operands against a plain a*b model.
module tb_mul256_seq;
  import mul256_seq_pkg::*;

  localparam int W  = MUL_W;
  localparam int PW = 2 * W;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          busy;
  logic          done;
  logic [PW-1:0] p;

  int tests_run = 0;
  int fails     = 0;
  int cyc       = 0;

  mul256_seq #(.W(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .p     (p)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [W-1:0] rnd_w();
    logic [W-1:0] v;
    for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [PW-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [PW-1:0] xx;
    logic [PW-1:0] yy;
    xx = {{W{1'b0}}, x};
    yy = {{W{1'b0}}, y};
    return xx * yy;
  endfunction

  // Stimulus only: issues one operation and reports what it observed.
  task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input bit hold,
                        output logic [PW-1:0] res, output int lat, output int busy_cyc,
                        output int p_chg);
    logic [PW-1:0] p0;
    p0 = p;
    a = ia; b = ib; start = 1'b1;
    tick();
    if (!hold) start = 1'b0;
    lat = 0; busy_cyc = 0; p_chg = 0;
    while (lat < 400) begin
      if (busy) busy_cyc++;
      if (hold) begin a = rnd_w(); b = rnd_w(); end
      tick();
      lat++;
      if (done) break;
      if (p !== p0) p_chg++;
    end
    start = 1'b0;
    res = p;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; a = rnd_w(); b = rnd_w();
    tick(); tick();
    tests_run++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    tests_run++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", done); end
    tests_run++; if (p !== '0) begin fails++; $display("FAIL reset_p got %h want 0", p); end
    start = 1'b0;
  endtask

  task automatic test_zero();
    logic [PW-1:0] res; int lat, bc, pc;
    rst = 1'b0;
    run_op('0, '1, 1'b0, res, lat, bc, pc);
    tests_run++; if (res !== '0) begin fails++; $display("FAIL zero_p got %h want 0", res); end
    tests_run++; if (lat != W) begin fails++; $display("FAIL zero_latency got %0d want %0d", lat, W); end
    tests_run++; if (bc != W) begin fails++; $display("FAIL zero_busy_cycles got %0d want %0d", bc, W); end
    tests_run++; if (busy !== 1'b0) begin fails++; $display("FAIL zero_busy_at_done got %b want 0", busy); end
    tick();
    tests_run++; if (done !== 1'b0) begin fails++; $display("FAIL zero_done_one_cycle got %b want 0", done); end
  endtask

  task automatic test_max();
    logic [PW-1:0] res, expv; int lat, bc, pc;
    expv = '0 - (PW'(1) << (W + 1)) + PW'(1);
    run_op('1, '1, 1'b0, res, lat, bc, pc);
    tests_run++; if (res !== expv) begin fails++; $display("FAIL max_p got %h want %h", res, expv); end
    tests_run++; if (pc != 0) begin fails++; $display("FAIL max_p_stable_in_run changes %0d want 0", pc); end
    tick();
  endtask

  task automatic test_reduce();
    logic [PW-1:0] res, prime, red; int lat, bc, pc;
    logic [W-1:0] ia;
    ia = '0; ia[W-1] = 1'b1;
    prime = (PW'(1) << W) - (PW'(1) << 32) - PW'(977);
    run_op(ia, W'(2), 1'b0, res, lat, bc, pc);
    tests_run++; if (res !== (PW'(1) << W)) begin fails++; $display("FAIL reduce_p got %h want 2^256", res); end
    red = res % prime;
    tests_run++; if (red !== PW'(33'h1_0000_03D1)) begin fails++; $display("FAIL reduce_mod got %h want 1000003d1", red); end
    tick();
  endtask

  task automatic test_idle_hold();
    logic [PW-1:0] p0; int bad;
    p0 = p; bad = 0;
    for (int i = 0; i < 6; i++) begin
      a = rnd_w(); b = rnd_w();
      tick();
      if (p !== p0 || busy !== 1'b0 || done !== 1'b0) bad++;
    end
    tests_run++; if (bad != 0) begin fails++; $display("FAIL idle_hold bad_cycles %0d want 0", bad); end
  endtask

  task automatic test_start_held();
    logic [PW-1:0] res, expv; logic [W-1:0] oa, ob; int lat, bc, pc, dn;
    oa = rnd_w(); ob = rnd_w();
    expv = ref_mul(oa, ob);
    run_op(oa, ob, 1'b1, res, lat, bc, pc);
    dn = done ? 1 : 0;
    tests_run++; if (res !== expv) begin fails++; $display("FAIL held_p got %h want %h", res, expv); end
    tests_run++; if (lat != W) begin fails++; $display("FAIL held_latency got %0d want %0d", lat, W); end
    for (int i = 0; i < 8; i++) begin tick(); if (done) dn++; end
    tests_run++; if (dn != 1) begin fails++; $display("FAIL held_done_count got %0d want 1", dn); end
  endtask

  task automatic test_rst_abort();
    logic [PW-1:0] res, expv; logic [W-1:0] ia, ib; int lat, bc, pc, dn;
    ia = rnd_w(); ib = rnd_w(); dn = 0;
    a = ia; b = ib; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 100; i++) begin tick(); if (done) dn++; end
    tests_run++; if (busy !== 1'b1) begin fails++; $display("FAIL abort_busy_mid got %b want 1", busy); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests_run++; if (busy !== 1'b0) begin fails++; $display("FAIL abort_busy got %b want 0", busy); end
    tests_run++; if (p !== '0) begin fails++; $display("FAIL abort_p got %h want 0", p); end
    if (done) dn++;
    ia = rnd_w(); ib = rnd_w();
    expv = ref_mul(ia, ib);
    run_op(ia, ib, 1'b0, res, lat, bc, pc);
    tests_run++; if (lat != W) begin fails++; $display("FAIL abort_restart_latency got %0d want %0d", lat, W); end
    tests_run++; if (res !== expv) begin fails++; $display("FAIL abort_restart_p got %h want %h", res, expv); end
    tests_run++; if (dn != 0) begin fails++; $display("FAIL abort_no_done got %0d pulses want 0", dn); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [PW-1:0] r1, r2; int lat, bc, pc, c1, c2;
    run_op(W'(3), W'(5), 1'b0, r1, lat, bc, pc);
    c1 = cyc;
    tick();
    tests_run++; if (done !== 1'b0) begin fails++; $display("FAIL b2b_done_low got %b want 0", done); end
    run_op(W'(7), W'(11), 1'b0, r2, lat, bc, pc);
    c2 = cyc;
    tests_run++; if (r1 !== PW'(15)) begin fails++; $display("FAIL b2b_first_p got %0d want 15", r1); end
    tests_run++; if (r2 !== PW'(77)) begin fails++; $display("FAIL b2b_second_p got %0d want 77", r2); end
    tests_run++; if (c2 - c1 != W + 2) begin fails++; $display("FAIL b2b_spacing got %0d want %0d", c2 - c1, W + 2); end
    tick();
  endtask

  task automatic test_random();
    logic [PW-1:0] res, expv; logic [W-1:0] ia, ib; int lat, bc, pc;
    for (int i = 0; i < 6; i++) begin
      ia = rnd_w(); ib = rnd_w();
      if (i == 4) ia = '1;
      if (i == 5) ib = W'(1);
      expv = ref_mul(ia, ib);
      run_op(ia, ib, 1'b0, res, lat, bc, pc);
      tests_run++; if (res !== expv) begin fails++; $display("FAIL random_p[%0d] got %h want %h", i, res, expv); end
      tests_run++; if (lat != W) begin fails++; $display("FAIL random_latency[%0d] got %0d want %0d", i, lat, W); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_max();
    test_reduce();
    test_idle_hold();
    test_start_held();
    test_rst_abort();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
